// File: rtl/exec_arith_unit.sv
// Adder, execute ALU and branch compare unit with optional registered copies of each result.
// Latency: add_result/alu_result/branch are combinational (0 cycles); *_q outputs are 1 cycle.
// Backpressure: none; cap_en only gates the capture registers, which otherwise hold.
module exec_arith_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_result,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  alu_control,
  output logic [31:0] alu_result,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [3:0]  bcu_control,
  output logic        branch,
  input  logic        cap_en,
  output logic [31:0] add_result_q,
  output logic [31:0] alu_result_q,
  output logic        branch_q
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_PASS = 5'd11;
  localparam logic [4:0] ALU_MUL  = 5'd12;

  localparam logic [3:0] BCU_NEVER  = 4'd0;
  localparam logic [3:0] BCU_BEQ    = 4'd1;
  localparam logic [3:0] BCU_BNE    = 4'd2;
  localparam logic [3:0] BCU_BLEZ   = 4'd3;
  localparam logic [3:0] BCU_BGTZ   = 4'd4;
  localparam logic [3:0] BCU_BLTZ   = 4'd5;
  localparam logic [3:0] BCU_BGEZ   = 4'd6;
  localparam logic [3:0] BCU_ALWAYS = 4'd7;

  logic [31:0] add_result_d;
  logic [31:0] alu_result_d;
  logic        branch_d;
  logic [4:0]  shamt;
  logic        rd1_neg;
  logic        rd1_zero;

  assign shamt    = src_b[4:0];
  assign rd1_neg  = rd1[31];
  assign rd1_zero = (rd1 == 32'd0);

  // Address adder: plain modulo-2^32 sum, carry dropped.
  always_comb begin
    add_result_d = add_a + add_b;
  end

  // Execute ALU; unused opcodes return zero.
  always_comb begin
    alu_result_d = 32'd0;
    case (alu_control)
      ALU_ADD:  alu_result_d = src_a + src_b;
      ALU_SUB:  alu_result_d = src_a - src_b;
      ALU_AND:  alu_result_d = src_a & src_b;
      ALU_OR:   alu_result_d = src_a | src_b;
      ALU_XOR:  alu_result_d = src_a ^ src_b;
      ALU_NOR:  alu_result_d = ~(src_a | src_b);
      ALU_SLT:  alu_result_d = {31'd0, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_result_d = {31'd0, (src_a < src_b)};
      ALU_SLL:  alu_result_d = src_a << shamt;
      ALU_SRL:  alu_result_d = src_a >> shamt;
      ALU_SRA:  alu_result_d = $signed(src_a) >>> shamt;
      ALU_PASS: alu_result_d = src_b;
      ALU_MUL:  alu_result_d = src_a * src_b;
      default:  alu_result_d = 32'd0;
    endcase
  end

  // Branch condition; zero-compares use rd1 sign bit and a zero detect.
  always_comb begin
    branch_d = 1'b0;
    case (bcu_control)
      BCU_NEVER:  branch_d = 1'b0;
      BCU_BEQ:    branch_d = (rd1 == rd2);
      BCU_BNE:    branch_d = (rd1 != rd2);
      BCU_BLEZ:   branch_d = rd1_neg | rd1_zero;
      BCU_BGTZ:   branch_d = ~rd1_neg & ~rd1_zero;
      BCU_BLTZ:   branch_d = rd1_neg;
      BCU_BGEZ:   branch_d = ~rd1_neg;
      BCU_ALWAYS: branch_d = 1'b1;
      default:    branch_d = 1'b0;
    endcase
  end

  assign add_result = add_result_d;
  assign alu_result = alu_result_d;
  assign branch     = branch_d;

  // Capture registers: cleared asynchronously, loaded only when cap_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_result_q <= 32'd0;
      alu_result_q <= 32'd0;
      branch_q     <= 1'b0;
    end else if (cap_en) begin
      add_result_q <= add_result_d;
      alu_result_q <= alu_result_d;
      branch_q     <= branch_d;
    end
  end

endmodule

// File: tb/tb_exec_arith_unit.sv
module tb_exec_arith_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_a, add_b, add_result;
  logic [31:0] src_a, src_b, alu_result;
  logic [4:0]  alu_control;
  logic [31:0] rd1, rd2;
  logic [3:0]  bcu_control;
  logic        branch;
  logic        cap_en;
  logic [31:0] add_result_q, alu_result_q;
  logic        branch_q;

  int total;
  int bad;

  exec_arith_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .src_a        (src_a),
    .src_b        (src_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .rd1          (rd1),
    .rd2          (rd2),
    .bcu_control  (bcu_control),
    .branch       (branch),
    .cap_en       (cap_en),
    .add_result_q (add_result_q),
    .alu_result_q (alu_result_q),
    .branch_q     (branch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models written from the arithmetic rules with wide integers.
  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned w;
    int sa, sb, sh;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    case (op)
      0:  begin w = longint'(a) + longint'(b); return w[31:0]; end
      1:  begin w = (longint'(a) + 64'h1_0000_0000) - longint'(b); return w[31:0]; end
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      8:  begin w = longint'(a) * (64'd1 << sh); return w[31:0]; end
      9:  begin w = longint'(a) / (64'd1 << sh); return w[31:0]; end
      10: return 32'(sa >>> sh);
      11: return b;
      12: begin w = longint'(a) * longint'(b); return w[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_bcu(input int op, input logic [31:0] r1, input logic [31:0] r2);
    int s1;
    s1 = r1;
    case (op)
      1: return r1 == r2;
      2: return r1 != r2;
      3: return s1 <= 0;
      4: return s1 > 0;
      5: return s1 < 0;
      6: return s1 >= 0;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cap_en = 1'b1;
    add_a = 32'd3; add_b = 32'd4;
    src_a = 32'd9; src_b = 32'd1; alu_control = 5'd0;
    rd1 = 32'd0; rd2 = 32'd0; bcu_control = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (add_result_q !== 32'd0 || alu_result_q !== 32'd0 || branch_q !== 1'b0) begin
      bad++;
      $display("FAIL reset_q got add=%h alu=%h br=%b want all 0", add_result_q, alu_result_q, branch_q);
    end
    total++;
    if (add_result !== 32'd7 || alu_result !== 32'd10 || branch !== 1'b1) begin
      bad++;
      $display("FAIL reset_comb got add=%h alu=%h br=%b want 7/a/1", add_result, alu_result, branch);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_adder();
    logic [31:0] av[4] = '{32'hFFFF_FFFC, 32'h0040_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bv[4] = '{32'd4, 32'd4, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ev[4] = '{32'd0, 32'h0040_0004, 32'hFFFF_FFFE, 32'd0};
    for (int i = 0; i < 4; i++) begin
      add_a = av[i]; add_b = bv[i];
      #1;
      total++;
      if (add_result !== ev[i]) begin
        bad++;
        $display("FAIL adder_dir%0d got=%h want=%h", i, add_result, ev[i]);
      end
    end
    for (int i = 0; i < 50; i++) begin
      add_a = $urandom; add_b = $urandom;
      #1;
      total++;
      if (add_result !== m_add(add_a, add_b)) begin
        bad++;
        $display("FAIL adder_rand a=%h b=%h got=%h want=%h", add_a, add_b, add_result, m_add(add_a, add_b));
      end
    end
  endtask

  task automatic test_alu();
    int          op[10]  = '{0, 1, 6, 7, 9, 10, 8, 5, 20, 12};
    logic [31:0] av[10] = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_0000,
                            32'hF0F0_0000, 32'hF0F0_0000, 32'd0, 32'h1234_5678, 32'h0001_0001};
    logic [31:0] bv[10] = '{32'd5, 32'd7, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'd0,
                            32'h9ABC_DEF0, 32'h0001_0001};
    logic [31:0] ev[10] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h0F0F_0000,
                            32'hFF0F_0000, 32'h0F00_0000, 32'hFFFF_FFFF, 32'd0, 32'h0002_0001};
    for (int i = 0; i < 10; i++) begin
      alu_control = 5'(op[i]); src_a = av[i]; src_b = bv[i];
      #1;
      total++;
      if (alu_result !== ev[i]) begin
        bad++;
        $display("FAIL alu_dir op=%0d got=%h want=%h", op[i], alu_result, ev[i]);
      end
    end
    for (int i = 0; i < 320; i++) begin
      alu_control = 5'(i % 32);
      src_a = $urandom; src_b = $urandom;
      if ((i / 32) % 3 == 1) src_a = {src_a[31], 31'd0} | (src_a & 32'hF);
      #1;
      total++;
      if (alu_result !== m_alu(i % 32, src_a, src_b)) begin
        bad++;
        $display("FAIL alu_rand op=%0d a=%h b=%h got=%h want=%h", i % 32, src_a, src_b,
                 alu_result, m_alu(i % 32, src_a, src_b));
      end
    end
  endtask

  task automatic test_bcu();
    int          op[10]  = '{1, 2, 5, 3, 4, 6, 6, 3, 9, 0};
    logic [31:0] r1v[10] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h8000_0000, 32'd0, 32'd0, 32'd5, 32'd5};
    logic [31:0] r2v[10] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd7, 32'd5, 32'd5};
    logic        ev[10]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bcu_control = 4'(op[i]); rd1 = r1v[i]; rd2 = r2v[i];
      #1;
      total++;
      if (branch !== ev[i]) begin
        bad++;
        $display("FAIL bcu_dir op=%0d rd1=%h got=%b want=%b", op[i], rd1, branch, ev[i]);
      end
    end
    for (int i = 0; i < 160; i++) begin
      bcu_control = 4'(i % 16);
      rd1 = $urandom;
      rd2 = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
      if ($urandom_range(0, 5) == 0) rd1 = 32'd0;
      #1;
      total++;
      if (branch !== m_bcu(i % 16, rd1, rd2)) begin
        bad++;
        $display("FAIL bcu_rand op=%0d rd1=%h rd2=%h got=%b want=%b", i % 16, rd1, rd2,
                 branch, m_bcu(i % 16, rd1, rd2));
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    alu_control = 5'd0; src_a = 32'd1; src_b = 32'd1;
    add_a = 32'd10; add_b = 32'd20; bcu_control = 4'd7;
    cap_en = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (alu_result_q !== 32'd2 || add_result_q !== 32'd30 || branch_q !== 1'b1) begin
      bad++;
      $display("FAIL reg_capture got alu=%h add=%h br=%b want 2/1e/1", alu_result_q, add_result_q, branch_q);
    end
    @(negedge clk);
    cap_en = 1'b0;
    src_a = 32'd50; src_b = 32'd60; add_a = 32'd1; bcu_control = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (alu_result_q !== 32'd2 || add_result_q !== 32'd30 || branch_q !== 1'b1) begin
      bad++;
      $display("FAIL reg_hold got alu=%h add=%h br=%b want 2/1e/1", alu_result_q, add_result_q, branch_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (add_result_q !== 32'd0 || alu_result_q !== 32'd0 || branch_q !== 1'b0) begin
      bad++;
      $display("FAIL async_clear got add=%h alu=%h br=%b want all 0", add_result_q, alu_result_q, branch_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cap_en = 1'b0;
    src_a = 32'd3; src_b = 32'd4; alu_control = 5'd0;
    add_a = 32'd8; add_b = 32'd8; bcu_control = 4'd7;
    @(posedge clk);
    #1;
    total++;
    if (add_result_q !== 32'd0 || alu_result_q !== 32'd0 || branch_q !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_hold got add=%h alu=%h br=%b want all 0", add_result_q, alu_result_q, branch_q);
    end
    @(negedge clk);
    cap_en = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (add_result_q !== 32'd16 || alu_result_q !== 32'd7 || branch_q !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_cap got add=%h alu=%h br=%b want 10/7/1", add_result_q, alu_result_q, branch_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_add, exp_alu;
    logic        exp_br;
    exp_add = add_result_q_seed();
    exp_alu = 32'd7;
    exp_br  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      add_a = $urandom; add_b = $urandom;
      src_a = $urandom; src_b = $urandom; alu_control = 5'($urandom_range(0, 15));
      rd1 = $urandom; rd2 = ($urandom_range(0, 1) == 0) ? rd1 : $urandom;
      bcu_control = 4'($urandom_range(0, 9));
      cap_en = 1'($urandom_range(0, 1));
      if (cap_en) begin
        exp_add = m_add(add_a, add_b);
        exp_alu = m_alu(int'(alu_control), src_a, src_b);
        exp_br  = m_bcu(int'(bcu_control), rd1, rd2);
      end
      @(posedge clk);
      #1;
      total++;
      if (add_result_q !== exp_add || alu_result_q !== exp_alu || branch_q !== exp_br) begin
        bad++;
        $display("FAIL b2b cyc=%0d got add=%h alu=%h br=%b want add=%h alu=%h br=%b", i,
                 add_result_q, alu_result_q, branch_q, exp_add, exp_alu, exp_br);
      end
    end
  endtask

  function automatic logic [31:0] add_result_q_seed();
    return 32'd16;
  endfunction

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_adder();
    test_alu();
    test_bcu();
    test_registered();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_arith_unit.md
# exec_arith_unit

Combinational arithmetic core of the pipelined MIPS datapath: a 32-bit two-operand adder (PC+4 and branch-target generation), the execute-stage ALU, and the decode-stage branch comparison unit, packaged as one block. All three results are available combinationally in the same cycle. A registered copy of each result, with an enable, is provided for pipelined consumers, and this copy is reset asynchronously.

## Interface
Parameters:
- None. The datapath is fixed at 32 bits and the shift amount is 5 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- add_a  in  32  adder operand A
- add_b  in  32  adder operand B
- add_result  out  32  add_a + add_b, combinational
- src_a  in  32  ALU operand A
- src_b  in  32  ALU operand B
- alu_control  in  5  ALU operation select
- alu_result  out  32  ALU result, combinational
- rd1  in  32  BCU operand 1 (rs value)
- rd2  in  32  BCU operand 2 (rt value)
- bcu_control  in  4  branch condition select
- branch  out  1  condition true, combinational
- cap_en  in  1  capture enable for the registered copies
- add_result_q  out  32  registered add_result
- alu_result_q  out  32  registered alu_result
- branch_q  out  1  registered branch

## Operation
Adder:
- The output is the sum modulo 2^32. Carry-out is discarded and there is no overflow flag.

ALU (alu_control):
- 0 ADD: a+b, wraps
- 1 SUB: a−b, wraps
- 2 AND
- 3 OR
- 4 XOR
- 5 NOR
- 6 SLT: signed a<b gives 1, otherwise 0
- 7 SLTU: unsigned compare
- 8 SLL: a << b[4:0]
- 9 SRL: a >> b[4:0], logical
- 10 SRA: a >>> b[4:0], sign-filling
- 11 PASS_B: b
- 12 MUL: low 32 bits of a*b
- All other codes (13–31) produce 32'h0.
- No exceptions are raised on overflow.

BCU (bcu_control); rd1/rd2 comparisons against zero are signed:
- 0 NEVER: branch=0
- 1 BEQ: rd1==rd2
- 2 BNE: rd1!=rd2
- 3 BLEZ: rd1<=0
- 4 BGTZ: rd1>0
- 5 BLTZ: rd1<0
- 6 BGEZ: rd1>=0
- 7 ALWAYS: branch=1
- Codes 8–15 produce branch=0.
- rd2 is ignored for codes 3–6.

Registered copies:
- On a rising clk edge with cap_en=1, each *_q register loads its combinational counterpart.
- With cap_en=0, the *_q registers hold their values.

## Timing
- add_result, alu_result and branch are purely combinational, with zero latency and no internal state.
- The *_q outputs have one-cycle latency and update only on a rising clk edge with cap_en=1.
- While rst_n=0, all *_q outputs are forced to 0 immediately, independent of clk. They stay 0 until the first enabled edge after rst_n rises.
- Reset has no effect on the combinational outputs.
- If reset is asserted mid-operation, the *_q outputs clear at once. Any capture pending on the same edge is lost.
- Any X on an operand input propagates to the corresponding output. The block does no X suppression.

## Test plan
- Adder wrap:
  - add_a=32'hFFFF_FFFC, add_b=4 → add_result=0.
  - add_a=32'h0040_0000, add_b=4 → 32'h0040_0004.
- ALU arithmetic and compare:
  - ADD 7+5=12.
  - SUB 5−7=32'hFFFF_FFFE.
  - SLT a=32'hFFFF_FFFF, b=1 → 1.
  - SLTU with the same operands → 0.
- ALU logic and shifts:
  - a=32'hF0F0_0000, b=32'h0000_0004: SRL=32'h0F0F_0000, SRA=32'hFF0F_0000, SLL=32'h0F00_0000.
  - NOR(0,0)=32'hFFFF_FFFF.
  - alu_control=20 → 0.
- BCU:
  - rd1=rd2=5: BEQ=1, BNE=0.
  - rd1=32'h8000_0000: BLTZ=1, BLEZ=1, BGTZ=0, BGEZ=0.
  - rd1=0: BGEZ=1, BLEZ=1.
  - bcu_control=9 → 0.
- Registered path:
  - Drive ADD 1+1 with cap_en=1 → alu_result_q=2 after the next rising edge.
  - Set cap_en=0 and change the operands → alu_result_q stays 2.
- Async reset:
  - Assert rst_n=0 between clock edges → all *_q outputs go to 0 immediately.
  - Release rst_n → the *_q outputs stay 0 until the next enabled edge.
